fetch_stage: RTL and testbench

Fetch stage of the aricriscv 5-stage pipeline. Consumes the predicted PC held in the F pipeline register (`F_predPC`), issues an instruction-memory request, buffers the returned instruction for decode, and computes the next predicted PC (`f_predPC`) that the F register captures. It also absorbs execute-stage redirects and raises a stall request toward pipeline control while a fetch is outstanding.

---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage of the aricriscv 5-stage pipeline.
//
// Takes the predicted PC from the F pipeline register, issues an instruction
// memory read, buffers the returned word for decode and produces the next
// predicted PC that the F register captures. Execute-stage redirects are
// absorbed here; a fetch that cannot be cancelled on the bus is drained
// and its data discarded.
//
// Parameters:
//   PC_WIDTH  PC / memory address width (>= 21)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   F_predPC_i      predicted PC from the F pipeline register
//   e_redirect_i    execute-stage redirect pulse
//   e_redirectPC_i  redirect target, valid with e_redirect_i
//   d_ready_i       decode accepts the presented instruction
//   imem_req_o      instruction memory request
//   imem_addr_o     request address, stable while imem_req_o is high
//   imem_ack_i      read data valid (same cycle as the request or later)
//   imem_rdata_i    instruction word, valid with imem_ack_i
//   f_valid_o       f_instr_o / f_pc_o hold a valid instruction (registered)
//   f_instr_o       buffered instruction (registered)
//   f_pc_o          address of f_instr_o (registered)
//   f_predPC_o      next predicted PC, to the F register input
//   f_stall_req_o   request to stall the F register
//
// Build option:
//   FETCH_BTFN_PREDICT_EN  predict backward conditional branches as taken;
//                          when undefined every branch predicts pc + 4.

module fetch_stage #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] F_predPC_i,
  input  logic                e_redirect_i,
  input  logic [PC_WIDTH-1:0] e_redirectPC_i,
  input  logic                d_ready_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [31:0]         imem_rdata_i,
  output logic                f_valid_o,
  output logic [31:0]         f_instr_o,
  output logic [PC_WIDTH-1:0] f_pc_o,
  output logic [PC_WIDTH-1:0] f_predPC_o,
  output logic                f_stall_req_o
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_WAIT,
    ST_VALID,
    ST_DRAIN
  } state_t;

  localparam logic [6:0]          OP_JAL  = 7'b1101111;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);
`ifdef FETCH_BTFN_PREDICT_EN
  localparam logic [6:0]          OP_BRANCH = 7'b1100011;
`endif

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [31:0]         instr_q;
  logic                valid_q;
  logic                redir_pend_q;
  logic [PC_WIDTH-1:0] redir_pc_q;

  logic [PC_WIDTH-1:0] sel_pc;
  logic [PC_WIDTH-1:0] j_imm;
  logic [PC_WIDTH-1:0] pred_pc;
`ifdef FETCH_BTFN_PREDICT_EN
  logic [PC_WIDTH-1:0] b_imm;
`endif

  // A live redirect beats a pending one, which beats the F register.
  assign sel_pc = e_redirect_i ? e_redirectPC_i :
                  redir_pend_q ? redir_pc_q     : F_predPC_i;

  assign j_imm = {{(PC_WIDTH-21){instr_q[31]}}, instr_q[31], instr_q[19:12],
                  instr_q[20], instr_q[30:21], 1'b0};
`ifdef FETCH_BTFN_PREDICT_EN
  assign b_imm = {{(PC_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                  instr_q[30:25], instr_q[11:8], 1'b0};
`endif

  always_comb begin
    pred_pc = pc_q + PC_STEP;
    if (instr_q[6:0] == OP_JAL) begin
      pred_pc = pc_q + j_imm;
    end
`ifdef FETCH_BTFN_PREDICT_EN
    // Sign bit of the B-immediate marks a backward branch.
    else if (instr_q[6:0] == OP_BRANCH && instr_q[31]) begin
      pred_pc = pc_q + b_imm;
    end
`endif
  end

  assign f_predPC_o    = rst_i ? RESET_PC + PC_STEP : pred_pc;
  assign imem_req_o    = !rst_i && (state_q != ST_VALID);
  assign imem_addr_o   = (state_q == ST_FETCH) ? sel_pc : pc_q;
  assign f_stall_req_o = rst_i ||
                         !(state_q == ST_VALID && d_ready_i && !e_redirect_i);

  assign f_valid_o = valid_q;
  assign f_instr_o = instr_q;
  assign f_pc_o    = pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b1;
      redir_pc_q   <= RESET_PC;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          pc_q         <= sel_pc;
          redir_pend_q <= 1'b0;
          if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (e_redirect_i) begin
            // Data arriving with the redirect is stale; without an ack the
            // bus still owes a response that must be drained.
            redir_pend_q <= 1'b1;
            redir_pc_q   <= e_redirectPC_i;
            state_q      <= imem_ack_i ? ST_FETCH : ST_DRAIN;
          end else if (imem_ack_i) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            state_q <= ST_VALID;
          end
        end
        ST_DRAIN: begin
          if (e_redirect_i) begin
            redir_pc_q <= e_redirectPC_i;
          end
          if (imem_ack_i) begin
            state_q <= ST_FETCH;
          end
        end
        ST_VALID: begin
          if (e_redirect_i) begin
            redir_pend_q <= 1'b1;
            redir_pc_q   <= e_redirectPC_i;
            valid_q      <= 1'b0;
            state_q      <= ST_FETCH;
          end else if (d_ready_i) begin
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int unsigned PW   = 32;
  localparam logic [31:0] RPC  = 32'h0;
  localparam logic [31:0] ADDI = 32'h00100093;
`ifdef FETCH_BTFN_PREDICT_EN
  localparam logic [31:0] BEQ_BACK_PRED = 32'h30;
`else
  localparam logic [31:0] BEQ_BACK_PRED = 32'h44;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fpred;
  logic        redir;
  logic [31:0] redir_pc;
  logic        d_ready;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] fpc;
  logic [31:0] pred;
  logic        stall;

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .F_predPC_i    (fpred),
    .e_redirect_i  (redir),
    .e_redirectPC_i(redir_pc),
    .d_ready_i     (d_ready),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_rdata_i  (rdata),
    .f_valid_o     (valid),
    .f_instr_o     (instr),
    .f_pc_o        (fpc),
    .f_predPC_o    (pred),
    .f_stall_req_o (stall)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference prediction straight from the ISA immediate definitions.
  function automatic int jal_imm(input logic [31:0] w);
    int v;
    v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    if (w[31]) v -= (1 << 20);
    return v;
  endfunction

  function automatic int br_imm(input logic [31:0] w);
    int v;
    v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
    if (w[31]) v -= 4096;
    return v;
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] w);
    if (w[6:0] == 7'b1101111) return pc + jal_imm(w);
`ifdef FETCH_BTFN_PREDICT_EN
    if (w[6:0] == 7'b1100011 && br_imm(w) < 0) return pc + br_imm(w);
`endif
    return pc + 32'd4;
  endfunction

  // Instruction memory: fixed override word or an address hash mixing
  // JAL, branch, ALU-imm and ALU-reg opcodes.
  logic        ovr_en;
  logic [31:0] ovr_word;
  int          fixed_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (ovr_en) return ovr_word;
    h = (a ^ 32'h5bd1e995) * 32'h9E3779B1;
    h = h ^ (h >> 15);
    case (h[1:0])
      2'd0:    return {h[31:7], 7'b0010011};
      2'd1:    return {h[31:7], 7'b1101111};
      2'd2:    return {h[31:7], 7'b1100011};
      default: return {h[31:7], 7'b0110011};
    endcase
  endfunction

  bit          mbusy = 0;
  int          mlat  = 0;
  logic [31:0] maddr = '0;

  always @(posedge clk) begin
    #2;
    if (!req) begin
      mbusy = 0;
      ack   = 1'b0;
    end else begin
      if (!mbusy) begin
        mbusy = 1;
        maddr = addr;
        mlat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end else begin
        chk("addr_stable", addr, maddr);
      end
      if (mlat == 0) begin
        ack   = 1'b1;
        rdata = mem_word(maddr);
        mbusy = 0;
      end else begin
        ack  = 1'b0;
        mlat = mlat - 1;
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] exp_pred;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] exp_pc;
  logic [31:0] fnext;
  logic [31:0] w;
  bit          apply_f;
  bit          prev_redir;
  int          consumed;

  initial begin
    vecs[0] = '{32'h0000_0000, ADDI,         32'h0000_0004};
    vecs[1] = '{32'h0000_0100, 32'hff9ff06f, 32'h0000_00F8};
    vecs[2] = '{32'hFFFF_FFFC, ADDI,         32'h0000_0000};
    vecs[3] = '{32'h0000_0040, 32'hFE0008E3, BEQ_BACK_PRED};
    vecs[4] = '{32'h0000_0040, 32'h00000463, 32'h0000_0044};
    vecs[5] = '{32'h0000_1000, 32'h010000EF, 32'h0000_1010};

    rst = 1'b1; d_ready = 1'b0; redir = 1'b0; redir_pc = '0; fpred = '0;
    ack = 1'b0; rdata = '0; ovr_en = 1'b1; ovr_word = ADDI; fixed_lat = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #3;
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stall), 1);
    chk("rst_pred", pred, RPC + 32'd4);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", fpc, 0);

    // First fetch, same-cycle ack
    @(posedge clk); #1 rst = 1'b0; #2;
    chk("f0_req", 32'(req), 1);
    chk("f0_addr", addr, RPC);
    chk("f0_stall", 32'(stall), 1);
    chk("f0_valid", 32'(valid), 0);
    @(posedge clk); #1 d_ready = 1'b1; #2;
    chk("v0_valid", 32'(valid), 1);
    chk("v0_pc", fpc, 0);
    chk("v0_instr", instr, ADDI);
    chk("v0_pred", pred, 32'h4);
    chk("v0_stall", 32'(stall), 0);
    chk("v0_req", 32'(req), 0);

    // Ack delayed 3 cycles
    @(posedge clk); #1 fpred = 32'h4; d_ready = 1'b0; fixed_lat = 3; #2;
    chk("f1_addr", addr, 32'h4);
    chk("f1_stall", 32'(stall), 1);
    chk("f1_valid", 32'(valid), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #3;
      chk("w1_addr", addr, 32'h4);
      chk("w1_req", 32'(req), 1);
      chk("w1_stall", 32'(stall), 1);
      chk("w1_valid", 32'(valid), 0);
    end

    // Hold in VALID with decode not ready
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #3;
      chk("hold_valid", 32'(valid), 1);
      chk("hold_pc", fpc, 32'h4);
      chk("hold_instr", instr, ADDI);
      chk("hold_pred", pred, 32'h8);
      chk("hold_stall", 32'(stall), 1);
      chk("hold_req", 32'(req), 0);
    end

    // Redirect beats d_ready rising in the same cycle
    @(posedge clk); #1 d_ready = 1'b1; redir = 1'b1; redir_pc = 32'h80; fixed_lat = 2; #2;
    chk("rv_stall", 32'(stall), 1);
    @(posedge clk); #1 redir = 1'b0; #2;
    chk("rv_addr", addr, 32'h80);
    chk("rv_valid", 32'(valid), 0);

    // Redirect in WAIT: drain the outstanding read, then fetch the target
    @(posedge clk); #1 redir = 1'b1; redir_pc = 32'h200; #2;
    chk("rw_addr", addr, 32'h80);
    @(posedge clk); #1 redir = 1'b0; fixed_lat = 0; #2;
    chk("drain_req", 32'(req), 1);
    chk("drain_addr", addr, 32'h80);
    chk("drain_valid", 32'(valid), 0);
    @(posedge clk); #3;
    chk("rd_addr", addr, 32'h200);
    chk("rd_valid", 32'(valid), 0);
    @(posedge clk); #1 d_ready = 1'b0; #2;
    chk("rd_vvalid", 32'(valid), 1);
    chk("rd_pc", fpc, 32'h200);
    chk("rd_pred", pred, 32'h204);

    // Prediction table: redirect to pc, serve the word, inspect VALID
    foreach (vecs[i]) begin
      @(posedge clk); #1 redir = 1'b1; redir_pc = vecs[i].pc; ovr_word = vecs[i].word; #2;
      @(posedge clk); #1 redir = 1'b0; #2;
      chk("vec_addr", addr, vecs[i].pc);
      @(posedge clk); #3;
      chk("vec_valid", 32'(valid), 1);
      chk("vec_pc", fpc, vecs[i].pc);
      chk("vec_instr", instr, vecs[i].word);
      chk("vec_pred", pred, vecs[i].exp_pred);
    end

    // Randomized run against a transaction-level model
    ovr_en = 1'b0; fixed_lat = -1; apply_f = 0; prev_redir = 0; consumed = 0;
    exp_pc = RPC;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst        = (i < 2) || ($urandom_range(0, 299) == 0);
      redir      = !rst && !prev_redir && ($urandom_range(0, 11) == 0);
      prev_redir = redir;
      redir_pc   = $urandom & 32'hFFFF_FFFC;
      d_ready    = ($urandom_range(0, 3) != 0);
      if (apply_f) fpred = fnext;
      apply_f = 0;
      #2;
      if (rst) begin
        chk("r_rst_req", 32'(req), 0);
        chk("r_rst_stall", 32'(stall), 1);
        exp_pc = RPC;
      end else if (redir) begin
        chk("r_redir_stall", 32'(stall), 1);
        exp_pc = redir_pc;
      end else if (valid && d_ready) begin
        w     = mem_word(exp_pc);
        fnext = predict(exp_pc, w);
        chk("r_pc", fpc, exp_pc);
        chk("r_instr", instr, w);
        chk("r_pred", pred, fnext);
        chk("r_stall", 32'(stall), 0);
        apply_f = 1;
        exp_pc  = fnext;
        consumed++;
      end else begin
        chk("r_idle_stall", 32'(stall), 1);
      end
    end
    chk("r_progress", 32'(consumed > 200), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
